// File: rtl/cu_pkg.sv
// Shared definitions for the control unit: opcodes, FSM state encoding,
// instruction classes and one-hot ALU select indices.
package cu_pkg;

    localparam int ALU_W = 13;

    localparam int ALU_AND  = 0;
    localparam int ALU_OR   = 1;
    localparam int ALU_ADD  = 2;
    localparam int ALU_SUB  = 3;
    localparam int ALU_MUL  = 4;
    localparam int ALU_DIV  = 5;
    localparam int ALU_SHR  = 6;
    localparam int ALU_SHRA = 7;
    localparam int ALU_SHL  = 8;
    localparam int ALU_ROR  = 9;
    localparam int ALU_ROL  = 10;
    localparam int ALU_NEG  = 11;
    localparam int ALU_NOT  = 12;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    typedef enum logic [1:0] {
        C_RRR, C_UNARY, C_MULDIV, C_ILLEGAL
    } iclass_t;

    function automatic logic [ALU_W-1:0] alu_bit(input int idx);
        alu_bit = ALU_W'(1) << idx;
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Opcode decoder: instruction class plus one-hot ALU select.
// CU_MULDIV_EN: when undefined, mul/div decode as illegal with no ALU bit.
module cu_decode
    import cu_pkg::*;
(
    input  logic [4:0]       opcode,
    output iclass_t          iclass,
    output logic [ALU_W-1:0] alu_sel
);

    always_comb begin
        iclass  = C_ILLEGAL;
        alu_sel = '0;
        case (opcode)
            OP_ADD:  begin iclass = C_RRR;   alu_sel = alu_bit(ALU_ADD);  end
            OP_SUB:  begin iclass = C_RRR;   alu_sel = alu_bit(ALU_SUB);  end
            OP_AND:  begin iclass = C_RRR;   alu_sel = alu_bit(ALU_AND);  end
            OP_OR:   begin iclass = C_RRR;   alu_sel = alu_bit(ALU_OR);   end
            OP_ROR:  begin iclass = C_RRR;   alu_sel = alu_bit(ALU_ROR);  end
            OP_ROL:  begin iclass = C_RRR;   alu_sel = alu_bit(ALU_ROL);  end
            OP_SHR:  begin iclass = C_RRR;   alu_sel = alu_bit(ALU_SHR);  end
            OP_SHRA: begin iclass = C_RRR;   alu_sel = alu_bit(ALU_SHRA); end
            OP_SHL:  begin iclass = C_RRR;   alu_sel = alu_bit(ALU_SHL);  end
            OP_NEG:  begin iclass = C_UNARY; alu_sel = alu_bit(ALU_NEG);  end
            OP_NOT:  begin iclass = C_UNARY; alu_sel = alu_bit(ALU_NOT);  end
`ifdef CU_MULDIV_EN
            OP_MUL:  begin iclass = C_MULDIV; alu_sel = alu_bit(ALU_MUL); end
            OP_DIV:  begin iclass = C_MULDIV; alu_sel = alu_bit(ALU_DIV); end
`else
            OP_MUL:  begin iclass = C_ILLEGAL; alu_sel = '0; end
            OP_DIV:  begin iclass = C_ILLEGAL; alu_sel = '0; end
`endif
            default: begin iclass = C_ILLEGAL; alu_sel = '0; end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit: fetch (T0-T2) then class-dependent execute steps.
// CU_MULDIV_EN enables the 7-cycle mul/div sequence (see cu_decode).
module control_unit
    import cu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       IR,
    input  logic              stop,
    output logic              PCout,
    output logic              IncPC,
    output logic              PCin,
    output logic              MARin,
    output logic              Read,
    output logic              MDRin,
    output logic              MDRout,
    output logic              IRin,
    output logic              Yin,
    output logic              Zin,
    output logic              Zlowout,
    output logic              Zhighout,
    output logic              HIin,
    output logic              LOin,
    output logic              Gra,
    output logic              Grb,
    output logic              Grc,
    output logic              Rin,
    output logic              Rout,
    output logic [ALU_W-1:0]  alu_sel,
    output logic              instr_done,
    output logic              illegal,
    output logic              halted
);

    state_t            state, state_nx;
    iclass_t           iclass;
    logic [ALU_W-1:0]  dec_alu;
    logic              unused_ir;

    // Register fields are consumed by the datapath, not by the sequencer.
    assign unused_ir = ^IR[26:0];

    cu_decode u_decode (
        .opcode  (IR[31:27]),
        .iclass  (iclass),
        .alu_sel (dec_alu)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_RST;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = S_T0;
        case (state)
            S_RST:  state_nx = S_T0;
            S_T0:   state_nx = stop ? S_HALT : S_T1;
            S_T1:   state_nx = S_T2;
            S_T2:   state_nx = (iclass == C_ILLEGAL) ? S_T0 : S_T3;
            S_T3:   state_nx = S_T4;
            S_T4:   state_nx = (iclass == C_UNARY) ? S_T0 : S_T5;
            S_T5:   state_nx = (iclass == C_MULDIV) ? S_T6 : S_T0;
            S_T6:   state_nx = S_T0;
            S_HALT: state_nx = stop ? S_HALT : S_T0;
            default: state_nx = S_RST;
        endcase
    end

    // Outputs are forced low while reset is held, even before RST is entered.
    always_comb begin
        PCout = 1'b0; IncPC = 1'b0; PCin = 1'b0; MARin = 1'b0;
        Read = 1'b0; MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0;
        Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0;
        HIin = 1'b0; LOin = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
        alu_sel = '0; instr_done = 1'b0; illegal = 1'b0; halted = 1'b0;
        if (!reset) begin
            case (state)
                S_T0: if (!stop) begin
                    PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; PCin = 1'b1;
                end
                S_T1: begin Read = 1'b1; MDRin = 1'b1; end
                S_T2: begin
                    MDRout = 1'b1; IRin = 1'b1;
                    illegal = (iclass == C_ILLEGAL);
                end
                S_T3: begin
                    Rout = 1'b1;
                    case (iclass)
                        C_RRR:    begin Grb = 1'b1; Yin = 1'b1; end
                        C_UNARY:  begin Grb = 1'b1; Zin = 1'b1; alu_sel = dec_alu; end
                        C_MULDIV: begin Gra = 1'b1; Yin = 1'b1; end
                        default:  Rout = 1'b0;
                    endcase
                end
                S_T4: begin
                    case (iclass)
                        C_RRR: begin
                            Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_sel = dec_alu;
                        end
                        C_MULDIV: begin
                            Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_sel = dec_alu;
                        end
                        C_UNARY: begin
                            Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; instr_done = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_T5: begin
                    case (iclass)
                        C_RRR: begin
                            Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; instr_done = 1'b1;
                        end
                        C_MULDIV: begin Zlowout = 1'b1; LOin = 1'b1; end
                        default: ;
                    endcase
                end
                S_T6: if (iclass == C_MULDIV) begin
                    Zhighout = 1'b1; HIin = 1'b1; instr_done = 1'b1;
                end
                S_HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed, table-driven bench for control_unit; one record per clock cycle.
module tb_control_unit;

    typedef logic [34:0] ov_t;

    typedef struct {
        logic        rst;
        logic        stp;
        logic [31:0] ir;
        ov_t         exp;
        string       name;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stop = 1'b0;
    logic [31:0] IR = 32'h0;
    logic PCout, IncPC, PCin, MARin, Read, MDRin, MDRout, IRin, Yin, Zin;
    logic Zlowout, Zhighout, HIin, LOin, Gra, Grb, Grc, Rin, Rout;
    logic [12:0] alu_sel;
    logic instr_done, illegal, halted;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    control_unit dut (
        .clk(clk), .reset(reset), .IR(IR), .stop(stop),
        .PCout(PCout), .IncPC(IncPC), .PCin(PCin), .MARin(MARin),
        .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
        .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout),
        .HIin(HIin), .LOin(LOin), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Rin(Rin), .Rout(Rout), .alu_sel(alu_sel),
        .instr_done(instr_done), .illegal(illegal), .halted(halted)
    );

    // Bit positions in the packed output vector.
    localparam int B_PCOUT = 34, B_INCPC = 33, B_PCIN = 32, B_MARIN = 31;
    localparam int B_READ = 30, B_MDRIN = 29, B_MDROUT = 28, B_IRIN = 27;
    localparam int B_YIN = 26, B_ZIN = 25, B_ZLO = 24, B_ZHI = 23;
    localparam int B_HIIN = 22, B_LOIN = 21, B_GRA = 20, B_GRB = 19, B_GRC = 18;
    localparam int B_RIN = 17, B_ROUT = 16, B_DONE = 2, B_ILL = 1, B_HALT = 0;

    function automatic ov_t b(input int i);
        b = ov_t'(1) << i;
    endfunction

    function automatic ov_t alu(input int k);
        alu = ov_t'(1) << (3 + k);
    endfunction

    function automatic ov_t actual();
        actual = {PCout, IncPC, PCin, MARin, Read, MDRin, MDRout, IRin, Yin, Zin,
                  Zlowout, Zhighout, HIin, LOin, Gra, Grb, Grc, Rin, Rout,
                  alu_sel, instr_done, illegal, halted};
    endfunction

    task automatic check(input string name, input ov_t exp);
        ov_t a;
        a = actual();
        n_cmp++;
        if (a !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, a, exp);
        end
        n_cmp++;
        if (($countones(alu_sel) > 1) || ($countones({Gra, Grb, Grc}) > 1) ||
            ($countones({PCout, MDRout, Rout, Zlowout, Zhighout}) > 1)) begin
            n_bad++;
            $display("FAIL %s_onehot: got alu=%h gr=%b bus=%b want at most one each",
                     name, alu_sel, {Gra, Grb, Grc},
                     {PCout, MDRout, Rout, Zlowout, Zhighout});
        end
    endtask

    task automatic step(input logic r, input logic s, input logic [31:0] ir,
                        input ov_t exp, input string name);
        @(negedge clk);
        reset = r; stop = s; IR = ir;
        #1 check(name, exp);
    endtask

    ov_t F0, F1, F2, Z;
    localparam logic [31:0] I_NEG = 32'h8A800000;
    localparam logic [31:0] I_ADD = 32'h18918000;
    localparam logic [31:0] I_BAD = 32'hF8000000;
    localparam logic [31:0] I_NOT = 32'h90000000;
    localparam logic [31:0] I_SHL = 32'h58000000;
    localparam logic [31:0] I_ZERO = 32'h00000000;
    localparam logic [31:0] I_MUL = 32'h79200000;

    rec_t tbl[$];

    task automatic add_fetch(input logic [31:0] ir, input string nm, input ov_t t2);
        tbl.push_back('{1'b0, 1'b0, ir, F0, {nm, "_t0"}});
        tbl.push_back('{1'b0, 1'b0, ir, F1, {nm, "_t1"}});
        tbl.push_back('{1'b0, 1'b0, ir, t2, {nm, "_t2"}});
    endtask

    initial begin
        Z  = '0;
        F0 = b(B_PCOUT) | b(B_MARIN) | b(B_INCPC) | b(B_PCIN);
        F1 = b(B_READ) | b(B_MDRIN);
        F2 = b(B_MDROUT) | b(B_IRIN);

        tbl.push_back('{1'b1, 1'b0, I_NEG, Z, "reset_hold"});
        tbl.push_back('{1'b0, 1'b0, I_NEG, Z, "rst_state"});
        add_fetch(I_NEG, "neg", F2);
        tbl.push_back('{1'b0, 1'b0, I_NEG, b(B_GRB) | b(B_ROUT) | alu(11) | b(B_ZIN), "neg_t3"});
        tbl.push_back('{1'b0, 1'b0, I_NEG, b(B_ZLO) | b(B_GRA) | b(B_RIN) | b(B_DONE), "neg_t4"});
        add_fetch(I_ADD, "add", F2);
        // stop is ignored outside T0/HALT
        tbl.push_back('{1'b0, 1'b1, I_ADD, b(B_GRB) | b(B_ROUT) | b(B_YIN), "add_t3"});
        tbl.push_back('{1'b0, 1'b0, I_ADD, b(B_GRC) | b(B_ROUT) | alu(2) | b(B_ZIN), "add_t4"});
        tbl.push_back('{1'b0, 1'b0, I_ADD, b(B_ZLO) | b(B_GRA) | b(B_RIN) | b(B_DONE), "add_t5"});
        add_fetch(I_BAD, "bad", F2 | b(B_ILL));
        add_fetch(I_NOT, "not", F2);
        tbl.push_back('{1'b0, 1'b0, I_NOT, b(B_GRB) | b(B_ROUT) | alu(12) | b(B_ZIN), "not_t3"});
        tbl.push_back('{1'b0, 1'b0, I_NOT, b(B_ZLO) | b(B_GRA) | b(B_RIN) | b(B_DONE), "not_t4"});
        add_fetch(I_SHL, "shl", F2);
        tbl.push_back('{1'b0, 1'b0, I_SHL, b(B_GRB) | b(B_ROUT) | b(B_YIN), "shl_t3"});
        tbl.push_back('{1'b0, 1'b0, I_SHL, b(B_GRC) | b(B_ROUT) | alu(8) | b(B_ZIN), "shl_t4"});
        tbl.push_back('{1'b0, 1'b0, I_SHL, b(B_ZLO) | b(B_GRA) | b(B_RIN) | b(B_DONE), "shl_t5"});
        add_fetch(I_ZERO, "op0", F2 | b(B_ILL));
        tbl.push_back('{1'b0, 1'b0, I_ZERO, F0, "after_op0_t0"});

        foreach (tbl[i]) step(tbl[i].rst, tbl[i].stp, tbl[i].ir, tbl[i].exp, tbl[i].name);

        // HALT entry and exit
        step(1'b1, 1'b0, I_ADD, Z, "h_reset");
        step(1'b0, 1'b0, I_ADD, Z, "h_rst");
        step(1'b0, 1'b1, I_ADD, Z, "h_t0_stop");
        step(1'b0, 1'b1, I_ADD, b(B_HALT), "h_halt1");
        step(1'b0, 1'b1, I_ADD, b(B_HALT), "h_halt2");
        step(1'b0, 1'b0, I_ADD, b(B_HALT), "h_halt_release");
        step(1'b0, 1'b0, I_ADD, F0, "h_resume_t0");
        step(1'b0, 1'b0, I_ADD, F1, "h_resume_t1");

        // reset in the middle of an add abandons it
        step(1'b1, 1'b0, I_ADD, Z, "m_reset");
        step(1'b0, 1'b0, I_ADD, Z, "m_rst");
        step(1'b0, 1'b0, I_ADD, F0, "m_t0");
        step(1'b0, 1'b0, I_ADD, F1, "m_t1");
        step(1'b0, 1'b0, I_ADD, F2, "m_t2");
        step(1'b0, 1'b0, I_ADD, b(B_GRB) | b(B_ROUT) | b(B_YIN), "m_t3");
        step(1'b1, 1'b0, I_ADD, Z, "m_t4_reset");
        step(1'b0, 1'b0, I_ADD, Z, "m_rst_after");
        step(1'b0, 1'b0, I_ADD, F0, "m_t0_after");

        // mul: full sequence with the macro, illegal without it
        step(1'b0, 1'b0, I_MUL, F1, "mul_t1");
`ifdef CU_MULDIV_EN
        step(1'b0, 1'b0, I_MUL, F2, "mul_t2");
        step(1'b0, 1'b0, I_MUL, b(B_GRA) | b(B_ROUT) | b(B_YIN), "mul_t3");
        step(1'b0, 1'b0, I_MUL, b(B_GRB) | b(B_ROUT) | alu(4) | b(B_ZIN), "mul_t4");
        step(1'b0, 1'b0, I_MUL, b(B_ZLO) | b(B_LOIN), "mul_t5");
        step(1'b0, 1'b0, I_MUL, b(B_ZHI) | b(B_HIIN) | b(B_DONE), "mul_t6");
`else
        step(1'b0, 1'b0, I_MUL, F2 | b(B_ILL), "mul_t2");
`endif
        step(1'b0, 1'b0, I_MUL, F0, "mul_next_t0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
